// File: rtl/vga_2048_pkg.sv
// Shared VGA 640x480@60 timing, board layout geometry and palette for the 2048 renderer.
package vga_2048_pkg;
  typedef logic [11:0] rgb_t;

  localparam logic [9:0] H_VIS  = 10'd640;
  localparam logic [9:0] H_FP   = 10'd16;
  localparam logic [9:0] H_SYNC = 10'd96;
  localparam logic [9:0] H_BP   = 10'd48;
  localparam logic [9:0] H_LAST = H_VIS + H_FP + H_SYNC + H_BP - 10'd1;
  localparam logic [9:0] H_SYNC_BEG = H_VIS + H_FP;
  localparam logic [9:0] H_SYNC_END = H_SYNC_BEG + H_SYNC - 10'd1;

  localparam logic [9:0] V_VIS  = 10'd480;
  localparam logic [9:0] V_FP   = 10'd10;
  localparam logic [9:0] V_SYNC = 10'd2;
  localparam logic [9:0] V_BP   = 10'd33;
  localparam logic [9:0] V_LAST = V_VIS + V_FP + V_SYNC + V_BP - 10'd1;
  localparam logic [9:0] V_SYNC_BEG = V_VIS + V_FP;
  localparam logic [9:0] V_SYNC_END = V_SYNC_BEG + V_SYNC - 10'd1;

  localparam logic [9:0] FRAME_X0 = 10'd120;
  localparam logic [9:0] FRAME_X1 = 10'd523;
  localparam logic [9:0] FRAME_Y0 = 10'd40;
  localparam logic [9:0] FRAME_Y1 = 10'd443;
  localparam logic [9:0] GRID_X   = 10'd520;
  localparam logic [9:0] GRID_Y   = 10'd440;
  localparam logic [9:0] CUR_Y0   = 10'd452;
  localparam logic [9:0] CUR_Y1   = 10'd467;
  localparam logic [6:0] TILE_LAST = 7'd99;
  localparam logic [6:0] GRID_W    = 7'd4;

  localparam rgb_t COL_GRID   = 12'h876;
  localparam rgb_t COL_CURSOR = 12'h0F0;
  localparam rgb_t COL_OVER   = 12'h800;
  localparam rgb_t COL_WIN    = 12'h080;
  localparam rgb_t COL_BG     = 12'h000;

  typedef struct packed {
    logic [15:0][5:0] board;
    logic [1:0]       cursor;
    logic             over;
    logic             win;
  } snap_t;

  function automatic rgb_t palette(input logic [5:0] e);
    case (e)
      6'd0:    palette = 12'h333;
      6'd1:    palette = 12'hEEE;
      6'd2:    palette = 12'hEDC;
      6'd3:    palette = 12'hF96;
      6'd4:    palette = 12'hF75;
      6'd5:    palette = 12'hF64;
      6'd6:    palette = 12'hF53;
      6'd7:    palette = 12'hED7;
      6'd8:    palette = 12'hEC6;
      6'd9:    palette = 12'hEC5;
      6'd10:   palette = 12'hEC3;
      default: palette = 12'hEC2;
    endcase
  endfunction
endpackage

// File: rtl/board_renderer_2048_vga_if.sv
// Game-core board/status inputs and VGA outputs of the 2048 board renderer.
interface board_renderer_2048_vga_if;
  logic [95:0] board_flat;
  logic [1:0]  cursor_col;
  logic        game_over;
  logic        game_win;
  logic        vga_hs;
  logic        vga_vs;
  logic [3:0]  vga_r;
  logic [3:0]  vga_g;
  logic [3:0]  vga_b;
  logic        frame_start;

  modport master (output board_flat, cursor_col, game_over, game_win,
                  input  vga_hs, vga_vs, vga_r, vga_g, vga_b, frame_start);
  modport slave  (input  board_flat, cursor_col, game_over, game_win,
                  output vga_hs, vga_vs, vga_r, vga_g, vga_b, frame_start);
endinterface

// File: rtl/vga_timing_2048.sv
// Pixel-rate divider, h/v raster counters and unregistered sync/visible decode.
module vga_timing_2048
  import vga_2048_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_tick,
  output logic [9:0] h,
  output logic [9:0] v,
  output logic       hs_raw,
  output logic       vs_raw,
  output logic       visible
);
  localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [TW-1:0] tick_cnt;

  assign pix_tick = (tick_cnt == TW'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
      h        <= '0;
      v        <= '0;
    end else begin
      tick_cnt <= pix_tick ? '0 : tick_cnt + TW'(1);
      if (pix_tick) begin
        if (h == H_LAST) begin
          h <= '0;
          v <= (v == V_LAST) ? '0 : v + 10'd1;
        end else begin
          h <= h + 10'd1;
        end
      end
    end
  end

  assign hs_raw  = !(h >= H_SYNC_BEG && h <= H_SYNC_END);
  assign vs_raw  = !(v >= V_SYNC_BEG && v <= V_SYNC_END);
  assign visible = (h < H_VIS) && (v < V_VIS);
endmodule

// File: rtl/board_renderer_2048_vga.sv
// Renders a per-frame snapshot of the 2048 board as tiles, grid, cursor bar and status background.
module board_renderer_2048_vga
  import vga_2048_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  board_renderer_2048_vga_if.slave bus
);
  logic       pix_tick, hs_raw, vs_raw, visible;
  logic [9:0] h, v;

  vga_timing_2048 #(.CLK_DIV(CLK_DIV)) u_timing (
    .clk(clk), .rst(rst), .pix_tick(pix_tick), .h(h), .v(v),
    .hs_raw(hs_raw), .vs_raw(vs_raw), .visible(visible)
  );

  // Latch on the tick that moves the raster to (0,480): first blanking line.
  logic  snap_evt;
  snap_t snap;
  logic  fs_q;

  assign snap_evt = pix_tick && (h == H_LAST) && (v == V_VIS - 10'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap <= '0;
      fs_q <= 1'b0;
    end else begin
      fs_q <= snap_evt;
      if (snap_evt)
        snap <= '{board: bus.board_flat, cursor: bus.cursor_col,
                  over: bus.game_over, win: bus.game_win};
    end
  end

  // Tile index/offset counters follow h and v, restarting one step before the frame origin.
  logic [1:0] col_idx, row_idx;
  logic [6:0] col_off, row_off;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_idx <= '0;
      col_off <= '0;
      row_idx <= '0;
      row_off <= '0;
    end else if (pix_tick) begin
      if (h == FRAME_X0 - 10'd1) begin
        col_idx <= '0;
        col_off <= '0;
      end else if (col_off == TILE_LAST) begin
        col_idx <= col_idx + 2'd1;
        col_off <= '0;
      end else begin
        col_off <= col_off + 7'd1;
      end
      if (h == H_LAST) begin
        if (v == FRAME_Y0 - 10'd1) begin
          row_idx <= '0;
          row_off <= '0;
        end else if (row_off == TILE_LAST) begin
          row_idx <= row_idx + 2'd1;
          row_off <= '0;
        end else begin
          row_off <= row_off + 7'd1;
        end
      end
    end
  end

  logic in_frame, is_grid, is_cursor;
  rgb_t color;

  assign in_frame  = (h >= FRAME_X0) && (h <= FRAME_X1) && (v >= FRAME_Y0) && (v <= FRAME_Y1);
  assign is_grid   = (col_off < GRID_W) || (row_off < GRID_W) || (h >= GRID_X) || (v >= GRID_Y);
  assign is_cursor = (v >= CUR_Y0) && (v <= CUR_Y1) && (h >= FRAME_X0) && (h < GRID_X) &&
                     (col_idx == snap.cursor) && (col_off >= GRID_W);

  always_comb begin
    color = snap.over ? COL_OVER : (snap.win ? COL_WIN : COL_BG);
    if (in_frame)
      color = is_grid ? COL_GRID : palette(snap.board[{row_idx, col_idx}]);
    else if (is_cursor)
      color = COL_CURSOR;
  end

  logic hs_q, vs_q;
  rgb_t rgb_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      rgb_q <= '0;
    end else if (pix_tick) begin
      hs_q  <= hs_raw;
      vs_q  <= vs_raw;
      rgb_q <= visible ? color : '0;
    end
  end

  assign bus.vga_hs      = hs_q;
  assign bus.vga_vs      = vs_q;
  assign bus.vga_r       = rgb_q[11:8];
  assign bus.vga_g       = rgb_q[7:4];
  assign bus.vga_b       = rgb_q[3:0];
  assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_board_renderer_2048_vga.sv
// Randomized scoreboard bench for the 2048 VGA board renderer against a geometric reference model.
`timescale 1ns/1ps
module tb_board_renderer_2048_vga;
  localparam int LINE  = 800;
  localparam int FRAME = 420000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  board_renderer_2048_vga_if bus();
  board_renderer_2048_vga_if bus4();

  board_renderer_2048_vga #(.CLK_DIV(1)) dut  (.clk(clk), .rst(rst), .bus(bus));
  board_renderer_2048_vga #(.CLK_DIV(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  int compared = 0, mismatched = 0;
  bit done4 = 0;

  typedef struct {int idx; logic [11:0] exp;} probe_t;
  probe_t q[$];

  // clocks since reset release; with one clk per pixel, the outputs after clk n show raster index n-1
  int n, c4;
  always @(posedge clk or posedge rst) if (rst) n <= 0; else n <= n + 1;
  always @(posedge clk or posedge rst) if (rst) c4 <= 0; else c4 <= c4 + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  function automatic logic [11:0] pal(input int e);
    logic [11:0] t [11] = '{12'h333, 12'hEEE, 12'hEDC, 12'hF96, 12'hF75, 12'hF64,
                            12'hF53, 12'hED7, 12'hEC6, 12'hEC5, 12'hEC3};
    return (e >= 11) ? 12'hEC2 : t[e];
  endfunction

  function automatic logic [11:0] model(input int x, input int y, input logic [95:0] b,
                                        input int cur, input bit go, input bit gw);
    int r, c;
    if (x >= 640 || y >= 480) return 12'h000;
    if (x >= 120 && x <= 523 && y >= 40 && y <= 443) begin
      if (x >= 520 || y >= 440 || (x - 120) % 100 < 4 || (y - 40) % 100 < 4) return 12'h876;
      r = (y - 40) / 100;
      c = (x - 120) / 100;
      return pal(int'(b[6*(4*r+c) +: 6]));
    end
    if (y >= 452 && y <= 467 && x >= 124 + 100*cur && x <= 219 + 100*cur) return 12'h0F0;
    return go ? 12'h800 : (gw ? 12'h080 : 12'h000);
  endfunction

  task automatic push(input int f, input int x, input int y, input logic [11:0] e);
    probe_t it;
    int i = 0;
    it.idx = f*FRAME + y*LINE + x;
    it.exp = e;
    while (i < q.size() && q[i].idx <= it.idx) i++;
    q.insert(i, it);
  endtask

  task automatic add_rand(input int f, input int ylo, input int yhi, input int cnt,
                          input logic [95:0] b, input int cur, input bit go, input bit gw);
    for (int k = 0; k < cnt; k++) begin
      int x, y;
      if (k % 2 == 0) begin
        x = 100 + $urandom_range(440);
        y = ylo + $urandom_range(yhi - ylo);
      end else begin
        x = $urandom_range(799);
        y = ylo + $urandom_range(yhi - ylo);
      end
      push(f, x, y, model(x, y, b, cur, go, gw));
    end
  endtask

  task automatic wait_n(input int t);
    while (n < t) @(negedge clk);
  endtask

  // Monitor: sync edges, blanking, frame_start and scoreboard pixels
  logic phs, pvs, pehs, pevs;
  always @(negedge clk) begin
    int idx, p, x, y;
    logic ehs, evs, efs;
    logic [11:0] rgb;
    if (rst) begin
      phs = 1; pvs = 1; pehs = 1; pevs = 1;
    end else if (n >= 1) begin
      idx = n - 1;
      p = idx % FRAME;
      y = p / LINE;
      x = p % LINE;
      rgb = {bus.vga_r, bus.vga_g, bus.vga_b};
      ehs = !(x >= 656 && x <= 751);
      evs = !(y >= 490 && y <= 491);
      efs = ((n % FRAME) == 384000);
      if (bus.vga_hs != phs || ehs != pehs) check($sformatf("hsync@(%0d,%0d)", x, y), bus.vga_hs, ehs);
      if (bus.vga_vs != pvs || evs != pevs) check($sformatf("vsync@(%0d,%0d)", x, y), bus.vga_vs, evs);
      phs = bus.vga_hs; pvs = bus.vga_vs; pehs = ehs; pevs = evs;
      if ((x >= 640 || y >= 480) && x % 50 == 0) check($sformatf("blank@(%0d,%0d)", x, y), rgb, 0);
      if (bus.frame_start || efs) check($sformatf("frame_start@%0d", n), bus.frame_start, efs);
      while (q.size() > 0 && q[0].idx < idx) begin
        check("probe_missed", idx, q[0].idx);
        void'(q.pop_front());
      end
      while (q.size() > 0 && q[0].idx == idx) begin
        check($sformatf("pixel(%0d,%0d)", x, y), rgb, q[0].exp);
        void'(q.pop_front());
      end
    end
  end

  // CLK_DIV=4 horizontal timing measured from the first reset release
  initial begin
    int f1 = -1, r1 = -1, f2 = -1;
    logic ph = 1'b1;
    @(negedge rst);
    repeat (8000) begin
      @(negedge clk);
      if (ph && !bus4.vga_hs) begin
        if (f1 < 0) f1 = c4; else if (f2 < 0) f2 = c4;
      end
      if (!ph && bus4.vga_hs && r1 < 0) r1 = c4;
      ph = bus4.vga_hs;
    end
    check("hs4_first_fall", f1, 2628);
    check("hs4_low_clk", r1 - f1, 384);
    check("hs4_period_clk", f2 - f1, 3200);
    done4 = 1;
  end

  initial begin
    #15_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [95:0] ba, bb;
    int cb;
    bus.board_flat = '0; bus.cursor_col = '0; bus.game_over = 0; bus.game_win = 0;
    bus4.board_flat = '0; bus4.cursor_col = '0; bus4.game_over = 0; bus4.game_win = 0;
    repeat (3) @(negedge clk);
    check("rst_hs", bus.vga_hs, 1);
    check("rst_vs", bus.vga_vs, 1);
    check("rst_rgb", {bus.vga_r, bus.vga_g, bus.vga_b}, 0);
    check("rst_fs", bus.frame_start, 0);
    check("rst_hs4", bus4.vga_hs, 1);

    // frame 0 renders the all-zero reset snapshot
    push(0, 10, 10, 12'h000);   push(0, 120, 40, 12'h876);  push(0, 170, 90, 12'h333);
    push(0, 521, 200, 12'h876); push(0, 170, 460, 12'h0F0); push(0, 330, 460, 12'h000);
    push(0, 700, 10, 12'h000);
    rst = 0;

    wait_n(2000);
    for (int i = 0; i < 16; i++) ba[6*i +: 6] = 6'($urandom_range(63));
    ba[5:0] = 6'd1; ba[6*15 +: 6] = 6'd11; ba[6*6 +: 6] = 6'd13;
    bus.board_flat = ba; bus.cursor_col = 2'd2; bus.game_over = 1; bus.game_win = 1;
    push(1, 170, 90, 12'hEEE);  push(1, 470, 390, 12'hEC2); push(1, 370, 190, 12'hEC2);
    push(1, 120, 40, 12'h876);  push(1, 521, 200, 12'h876); push(1, 10, 10, 12'h800);
    push(1, 700, 10, 12'h000);  push(1, 330, 460, 12'h0F0); push(1, 230, 460, 12'h800);
    add_rand(1, 0, 524, 24, ba, 2, 1, 1);

    // mid-frame change at v=200 of frame 1: only frame 2 may show it
    wait_n(FRAME + 200*LINE);
    bb = ba;
    bb[5:0] = 6'd2;
    for (int i = 8; i < 16; i++) bb[6*i +: 6] = 6'($urandom_range(63));
    cb = $urandom_range(3);
    bus.board_flat = bb; bus.cursor_col = 2'(cb); bus.game_over = 0; bus.game_win = 1;
    add_rand(1, 210, 524, 12, ba, 2, 1, 1);
    push(1, 330, 460, 12'h0F0);
    push(2, 170, 90, 12'hEDC); push(2, 10, 10, 12'h080);
    add_rand(2, 0, 290, 20, bb, cb, 0, 1);
    push(2, 150 + 100*cb, 460 - 180, model(150 + 100*cb, 280, bb, cb, 0, 1));

    // asynchronous reset in the middle of a tile row
    wait_n(2*FRAME + 300*LINE + 300);
    rst = 1;
    #1;
    check("midrst_rgb", {bus.vga_r, bus.vga_g, bus.vga_b}, 0);
    check("midrst_hs", bus.vga_hs, 1);
    check("midrst_vs", bus.vga_vs, 1);
    check("midrst_fs", bus.frame_start, 0);
    check("leftover_probes", q.size(), 0);
    q.delete();
    @(negedge clk);
    push(0, 170, 90, 12'h333); push(0, 10, 10, 12'h000); push(0, 250, 460, 12'h000);
    rst = 0;
    wait_n(470*LINE);
    check("leftover_probes2", q.size(), 0);
    check("hs4_done", done4, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
